// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick divider.
package clk_div_pkg;

  localparam int MIN_DIV         = 2;
  localparam int DEFAULT_DIV_1HZ = 50_000_000;
  localparam int CNT_W_DEFAULT   = 26;
  localparam int HALF_W          = 64;

  function automatic logic [HALF_W-1:0] half_up(input logic [HALF_W-1:0] d);
    return (d + HALF_W'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: modulo-D counter, shadowed divisor applied at period boundary, registered level/tick.
// Optional phase-align input sync_i exists only when CLKDIV_SYNC_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             en_i,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap, restart, apply;

  always_comb begin
    wrap = (count_q == div_act_q - CNT_W'(1));
`ifdef CLKDIV_SYNC_EN
    restart = !en_i || sync_i;
`else
    restart = !en_i;
`endif
    // Every path that returns the counter to phase 0 is also a safe point to switch divisors.
    apply        = restart || wrap;
    count_d      = apply ? '0 : count_q + CNT_W'(1);
    div_act_d    = apply ? div_shadow_q : div_act_q;
    pend_d       = apply ? 1'b0 : pend_q;
    div_shadow_d = div_shadow_q;
    if (we_i) begin
      div_shadow_d = (div_i < DIV_MIN) ? DIV_MIN : div_i;
      pend_d       = 1'b1;
    end
    // Outputs describe the post-edge phase so they stay aligned with count_q.
    tick_d    = (count_d == div_act_d - CNT_W'(1));
    clk_out_d = (HALF_W'(count_d) >= half_up(HALF_W'(div_act_d)));
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      div_act_q    <= DIV_RST;
      div_shadow_q <= DIV_RST;
      pend_q       <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_act_q    <= div_act_d;
      div_shadow_q <= div_shadow_d;
      pend_q       <= pend_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator; single config port fans out to NUM_CH channels.
// Define CLKDIV_SYNC_EN to add the sync phase-align input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = CNT_W_DEFAULT,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_1HZ,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // Out-of-range channel numbers are dropped rather than aliased onto a real channel.
  logic cfg_ok;
  assign cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg_ok && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_50mhz (clk_50mhz),
      .reset     (reset),
      .en_i      (en[i]),
`ifdef CLKDIV_SYNC_EN
      .sync_i    (sync),
`endif
      .we_i      (we_ch),
      .div_i     (cfg_div),
      .pend_o    (pend[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with a 10-cycle default divisor and five channels.
module tb_clk_div_multi;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 26;
  localparam int CH_W   = 3;

  logic              clk_50mhz;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  logic [NUM_CH-1:0] tk_h [64];
  logic [NUM_CH-1:0] co_h [64];
  logic [NUM_CH-1:0] pd_h [64];
  logic [NUM_CH-1:0] pall;

  int n_chk  = 0;
  int n_pass = 0;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (10)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .pend      (pend),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(div);
  endtask

  // Sample i holds the outputs after the (i+1)-th rising edge of the series.
  task automatic smp(input int i);
    @(negedge clk_50mhz);
    tk_h[i] = tick;
    co_h[i] = clk_out;
    pd_h[i] = pend;
    cfg_we  = 1'b0;
  endtask

  function automatic logic [63:0] hv(input int ch, input int n, input int sel);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      case (sel)
        0:       v[k] = tk_h[k][ch];
        1:       v[k] = co_h[k][ch];
        default: v[k] = pd_h[k][ch];
      endcase
    end
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    en      = '0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    sync    = 1'b0;

    #12;
    chk("reset_pend", 64'(pend), 64'h0);
    chk("reset_clk_out", 64'(clk_out), 64'h0);
    chk("reset_tick", 64'(tick), 64'h0);

    // Default divisor on ch0
    @(negedge clk_50mhz);
    reset = 1'b0;
    en[0] = 1'b1;
    for (int i = 0; i < 20; i++) smp(i);
    chk("ch0_default_tick", hv(0, 20, 0), 64'h40100);
    chk("ch0_default_clk", hv(0, 20, 1), 64'h7C1F0);

    // ch1 divisor 3 written while running
    en[1] = 1'b1;
    wr(1, 3);
    for (int i = 0; i < 16; i++) smp(i);
    chk("ch1_d3_pend", hv(1, 16, 2), 64'h1FF);
    chk("ch1_d3_tick", hv(1, 16, 0), 64'h4900);
    chk("ch1_d3_clk", hv(1, 16, 1), 64'h49F0);
    en[1] = 1'b0;

    // Clamp of 0 and 1 to 2
    for (int v = 0; v < 2; v++) begin
      en[0] = 1'b0;
      wr(0, v);
      smp(0);
      smp(1);
      chk("clamp_pend_set", 64'(pd_h[0][0]), 64'h1);
      chk("clamp_pend_clr", 64'(pd_h[1][0]), 64'h0);
      en[0] = 1'b1;
      for (int i = 0; i < 6; i++) smp(i);
      chk("clamp_tick", hv(0, 6, 0), 64'h15);
      chk("clamp_clk", hv(0, 6, 1), 64'h15);
    end
    en[0] = 1'b0;

    // ch2: two writes (last wins) plus an out-of-range write
    en[2] = 1'b1;
    pall  = '0;
    for (int i = 0; i < 22; i++) begin
      smp(i);
      if (i == 3) pall = pend;
      if (i == 0) wr(2, 8);
      if (i == 1) wr(2, 6);
      if (i == 2) wr(NUM_CH, 3);
    end
    chk("ch2_pend", hv(2, 22, 2), 64'h1FE);
    chk("oor_pend_all", 64'(pall), 64'h04);
    chk("ch2_tick", hv(2, 22, 0), 64'h104100);
    chk("ch2_clk", hv(2, 22, 1), 64'h1C71F0);

    // ch3: disable mid-period with a pending divisor, then restart
    en[3] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      smp(i);
      if (i == 1) wr(3, 4);
      if (i == 5) en[3] = 1'b0;
      if (i == 6) en[3] = 1'b1;
    end
    chk("ch3_pend", hv(3, 14, 2), 64'h3C);
    chk("ch3_clk", hv(3, 14, 1), 64'h3330);
    chk("ch3_tick", hv(3, 14, 0), 64'h2200);
    en[3] = 1'b0;

`ifdef CLKDIV_SYNC_EN
    // ch0 D=4 and ch1 D=6 out of phase, then aligned by sync
    wr(0, 4);
    smp(0);
    wr(1, 6);
    smp(1);
    smp(2);
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) smp(i);
    en[1] = 1'b1;
    for (int i = 0; i < 2; i++) smp(i);
    sync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      smp(i);
      sync = 1'b0;
    end
    chk("sync_ch0_tick", hv(0, 12, 0), 64'h888);
    chk("sync_ch1_tick", hv(1, 12, 0), 64'h820);
    chk("sync_ch0_clk", hv(0, 12, 1), 64'hCCC);
    chk("sync_ch1_clk", hv(1, 12, 1), 64'hE38);
`endif

    // Asynchronous reset between edges discards a pending shadow
    wr(4, 5);
    smp(0);
    chk("pre_reset_pend4", 64'(pd_h[0][4]), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pend", 64'(pend), 64'h0);
    chk("async_reset_clk_out", 64'(clk_out), 64'h0);
    chk("async_reset_tick", 64'(tick), 64'h0);
    @(negedge clk_50mhz);
    reset = 1'b0;
    en    = 5'b00100;
    for (int i = 0; i < 10; i++) smp(i);
    chk("post_reset_ch2_tick", hv(2, 10, 0), 64'h100);
    chk("post_reset_ch4_pend", hv(4, 10, 2), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
